// File: rtl/fpnew_req_queue.sv
// In-order request FIFO in front of an FPU. It caps the number of in-flight requests
// and supports a fence that drains every outstanding result before issue resumes.
module fpnew_req_queue #(
  parameter int unsigned ReqWidth       = 256,
  parameter int unsigned Depth          = 4,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [ReqWidth-1:0]                 req_i,
  output logic                                fpu_valid_o,
  input  logic                                fpu_ready_i,
  output logic [ReqWidth-1:0]                 fpu_req_o,
  input  logic                                res_valid_i,
  input  logic                                res_ready_i,
  input  logic                                fence_i,
  output logic                                fence_done_o,
  output logic [$clog2(Depth):0]              usage_o,
  output logic [$clog2(MaxOutstanding):0]     outstanding_o,
  output logic                                busy_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned UsageW = $clog2(Depth) + 1;
  localparam int unsigned OutW   = $clog2(MaxOutstanding) + 1;

  localparam logic [UsageW-1:0] FullCount = UsageW'(Depth);
  localparam logic [OutW-1:0]   MaxCount  = OutW'(MaxOutstanding);

  typedef enum logic {
    RUN,
    FENCE
  } state_e;

  state_e              state_q, state_d;
  logic [UsageW-1:0]   usage_q, usage_d;
  logic [OutW-1:0]     out_q, out_d;
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [ReqWidth-1:0] mem_q [Depth];

  logic push, pop, retire;

  assign in_ready_o  = (usage_q != FullCount) && !flush_i;
  assign fpu_valid_o = (usage_q != '0) && (state_q == RUN) && (out_q != MaxCount) && !flush_i;
  assign fpu_req_o   = mem_q[rptr_q];

  assign push   = in_valid_i && in_ready_o;
  assign pop    = fpu_valid_o && fpu_ready_i;
  assign retire = res_valid_i && res_ready_i && !flush_i;

  assign usage_o       = usage_q;
  assign outstanding_o = out_q;
  assign busy_o        = (usage_q != '0) || (out_q != '0) || (state_q == FENCE);

  // The fence completes in the cycle the registered in-flight count is seen at zero.
  always_comb begin
    state_d      = state_q;
    fence_done_o = 1'b0;
    if (flush_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (fence_i) state_d = FENCE;
        end
        FENCE: begin
          if (out_q == '0) begin
            state_d      = RUN;
            fence_done_o = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    usage_d = usage_q;
    out_d   = out_q;
    if (flush_i) begin
      usage_d = '0;
      out_d   = '0;
    end else begin
      if (push && !pop)      usage_d = usage_q + UsageW'(1);
      else if (!push && pop) usage_d = usage_q - UsageW'(1);
      // A retire with nothing in flight is a protocol error; the count stays at zero.
      if (pop && !retire)                      out_d = out_q + OutW'(1);
      else if (!pop && retire && out_q != '0)  out_d = out_q - OutW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      usage_q <= '0;
      out_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      usage_q <= usage_d;
      out_q   <= out_d;
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PtrW'(1);
        if (pop)  rptr_q <= rptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= req_i;
  end

  retire_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(retire && !pop && out_q == '0));

endmodule

// File: tb/tb_fpnew_req_queue.sv
// Scoreboard bench for fpnew_req_queue: issued payloads are checked against a queue of
// accepted requests, and occupancy/fence/flush/reset behaviour is checked at fixed points.
module tb_fpnew_req_queue;

  localparam int unsigned ReqWidth = 256;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush, in_valid, in_ready, fpu_valid, fpu_ready;
  logic                res_valid, res_ready, fence, fence_done, busy;
  logic [ReqWidth-1:0] req, fpu_req;
  logic [2:0]          usage;
  logic [3:0]          outstanding;

  logic [ReqWidth-1:0] exp_q[$];
  int vectors  = 0;
  int failures = 0;
  int issue_cnt = 0;
  int push_cnt  = 0;

  fpnew_req_queue #(.ReqWidth(ReqWidth), .Depth(4), .MaxOutstanding(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .req_i(req),
    .fpu_valid_o(fpu_valid), .fpu_ready_i(fpu_ready), .fpu_req_o(fpu_req),
    .res_valid_i(res_valid), .res_ready_i(res_ready),
    .fence_i(fence), .fence_done_o(fence_done),
    .usage_o(usage), .outstanding_o(outstanding), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [ReqWidth-1:0] pl(input int n);
    return {8{32'hA500_0000 + n}};
  endfunction

  task automatic checkOutput(input string tag, input logic [ReqWidth-1:0] got,
                             input logic [ReqWidth-1:0] exp);
    vectors++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the active edge.
  task automatic applyStimulus(input logic v, input logic [ReqWidth-1:0] d, input logic fr,
                               input logic rv, input logic fl, input logic fe);
    in_valid  = v;
    req       = d;
    fpu_ready = fr;
    res_valid = rv;
    res_ready = rv;
    flush     = fl;
    fence     = fe;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted payloads queue up, each FPU handshake must present the oldest.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (fpu_valid && fpu_ready) begin
        issue_cnt++;
        if (exp_q.size() == 0) checkOutput("sb_underflow", exp_q.size(), 1);
        else checkOutput("fifo_order", fpu_req, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(req);
        push_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int i0, p0;
    rst_n = 1'b0;
    in_valid = 0; req = '0; fpu_ready = 0; res_valid = 0; res_ready = 0; flush = 0; fence = 0;
    #3;
    checkOutput("rst_usage", usage, 0);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_fpu_valid", fpu_valid, 0);
    checkOutput("rst_fence_done", fence_done, 0);
    checkOutput("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill with the FPU stalled, then drain in order on consecutive cycles.
    for (int i = 0; i < 4; i++) applyStimulus(1, pl(i), 0, 0, 0, 0);
    checkOutput("full_usage", usage, 4);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("stall_valid", fpu_valid, 1);
    checkOutput("stall_hold", fpu_req, pl(0));
    i0 = issue_cnt;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 1, 0, 0, 0);
      checkOutput("issue_consec", issue_cnt - i0, i + 1);
    end
    checkOutput("drain_valid", fpu_valid, 0);
    checkOutput("drain_outstanding", outstanding, 4);
    for (int i = 0; i < 4; i++) applyStimulus(0, '0, 0, 1, 0, 0);
    checkOutput("retire_outstanding", outstanding, 0);

    // Outstanding cap: nine requests, only eight may issue without a retire.
    i0 = issue_cnt;
    p0 = push_cnt;
    for (int c = 0; c < 60 && (push_cnt - p0) < 9; c++)
      applyStimulus(1, pl(100 + push_cnt - p0), 1, 0, 0, 0);
    checkOutput("cap_pushes", push_cnt - p0, 9);
    repeat (2) applyStimulus(0, '0, 1, 0, 0, 0);
    checkOutput("cap_issues", issue_cnt - i0, 8);
    checkOutput("cap_valid", fpu_valid, 0);
    checkOutput("cap_outstanding", outstanding, 8);
    checkOutput("cap_usage", usage, 1);
    applyStimulus(0, '0, 1, 1, 0, 0);
    checkOutput("cap_retire_out", outstanding, 7);
    checkOutput("cap_valid_again", fpu_valid, 1);
    applyStimulus(0, '0, 1, 0, 0, 0);
    checkOutput("cap_ninth_issue", issue_cnt - i0, 9);
    checkOutput("cap_out_full", outstanding, 8);
    for (int i = 0; i < 8; i++) applyStimulus(0, '0, 0, 1, 0, 0);
    checkOutput("cap_drained", outstanding, 0);

    // Fence with three in flight: pushes continue, issue waits for all retires.
    for (int i = 0; i < 3; i++) applyStimulus(1, pl(300 + i), 1, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0, 0);
    checkOutput("fence_pre_out", outstanding, 3);
    applyStimulus(0, '0, 0, 0, 0, 1);
    checkOutput("fence_enter_done", fence_done, 0);
    checkOutput("fence_busy", busy, 1);
    i0 = issue_cnt;
    for (int i = 0; i < 2; i++) applyStimulus(1, pl(310 + i), 1, 0, 0, 0);
    checkOutput("fence_push_usage", usage, 2);
    checkOutput("fence_block_valid", fpu_valid, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, '0, 1, 1, 0, 0);
      checkOutput("fence_done_pulse", fence_done, (i == 2));
      checkOutput("fence_no_issue", issue_cnt - i0, 0);
    end
    applyStimulus(0, '0, 1, 0, 0, 0);
    checkOutput("fence_done_clear", fence_done, 0);
    checkOutput("fence_resume_valid", fpu_valid, 1);
    applyStimulus(0, '0, 1, 0, 0, 0);
    checkOutput("fence_resume_issue", issue_cnt - i0, 1);
    applyStimulus(0, '0, 1, 0, 0, 0);
    repeat (2) applyStimulus(0, '0, 0, 1, 0, 0);
    checkOutput("fence_end_out", outstanding, 0);

    // Fence with nothing in flight completes on the following cycle.
    applyStimulus(0, '0, 0, 0, 0, 1);
    checkOutput("fence0_done", fence_done, 1);
    checkOutput("fence0_busy", busy, 1);
    applyStimulus(0, '0, 0, 0, 0, 0);
    checkOutput("fence0_clear", fence_done, 0);
    checkOutput("fence0_idle", busy, 0);

    // Flush with a full queue, five in flight, and a same-cycle push and retire.
    for (int i = 0; i < 5; i++) applyStimulus(1, pl(500 + i), 1, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, pl(510 + i), 0, 0, 0, 0);
    checkOutput("preflush_out", outstanding, 5);
    checkOutput("preflush_usage", usage, 4);
    applyStimulus(1, pl(599), 1, 1, 1, 0);
    applyStimulus(0, '0, 0, 0, 0, 0);
    checkOutput("flush_usage", usage, 0);
    checkOutput("flush_out", outstanding, 0);
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_in_ready", in_ready, 1);

    // Steady push+pop at occupancy two, wrapping the pointers several times.
    applyStimulus(1, pl(200), 0, 0, 0, 0);
    applyStimulus(1, pl(201), 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, pl(202 + i), 1, (i > 0), 0, 0);
      checkOutput("wrap_usage", usage, 2);
    end
    checkOutput("wrap_out", outstanding, 1);
    repeat (2) applyStimulus(0, '0, 1, 1, 0, 0);
    applyStimulus(0, '0, 0, 1, 0, 0);
    checkOutput("wrap_drain_usage", usage, 0);
    checkOutput("wrap_drain_out", outstanding, 0);
    checkOutput("sb_empty", exp_q.size(), 0);

    // Asynchronous reset while fenced with three queued entries.
    applyStimulus(1, pl(400), 1, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, pl(401 + i), 0, 0, 0, 0);
    checkOutput("prereset_usage", usage, 3);
    in_valid = 0; fpu_ready = 0; fence = 0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_usage", usage, 0);
    checkOutput("arst_out", outstanding, 0);
    checkOutput("arst_in_ready", in_ready, 1);
    checkOutput("arst_fpu_valid", fpu_valid, 0);
    checkOutput("arst_fence_done", fence_done, 0);
    checkOutput("arst_busy", busy, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, '0, 0, 0, 0, 0);
      checkOutput("post_rst_fence_done", fence_done, 0);
      checkOutput("post_rst_busy", busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule

// File: doc/fpnew_req_queue.md
FPNEW_REQ_QUEUE -- requirements
Module: fpnew_req_queue

Interface
REQ-001 SHALL have parameter ReqWidth, default 256: width of one packed FPU request (operands, rnd_mode, op, op_mod, src/dst/int fmt, vectorial_op, tag); contents opaque to this block.
REQ-002 SHALL have parameter Depth, default 4: request FIFO entries, power of two, >= 2.
REQ-003 SHALL have parameter MaxOutstanding, default 8: maximum requests accepted by the FPU whose results are not yet retired, >= 1.
REQ-004 SHALL have port clk_i  in  1  clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port flush_i  in  1  synchronous flush of queue and outstanding count.
REQ-007 SHALL have port in_valid_i  in  1  core request valid.
REQ-008 SHALL have port in_ready_o  out  1  queue can accept a request.
REQ-009 SHALL have port req_i  in  ReqWidth  core request payload.
REQ-010 SHALL have port fpu_valid_o  out  1  request offered to FPU.
REQ-011 SHALL have port fpu_ready_i  in  1  FPU accepts request.
REQ-012 SHALL have port fpu_req_o  out  ReqWidth  head-of-queue payload.
REQ-013 SHALL have port res_valid_i  in  1  FPU result valid (monitored only).
REQ-014 SHALL have port res_ready_i  in  1  result consumer ready (monitored only).
REQ-015 SHALL have port fence_i  in  1  single-cycle fence request.
REQ-016 SHALL have port fence_done_o  out  1  single-cycle pulse: fence completed.
REQ-017 SHALL have port usage_o  out  $clog2(Depth)+1  FIFO occupancy.
REQ-018 SHALL have port outstanding_o  out  $clog2(MaxOutstanding)+1  in-flight count.
REQ-019 SHALL have port busy_o  out  1  queue non-empty, outstanding non-zero, or state FENCE.

Function
REQ-020 SHALL implement an in-order FIFO with registered storage and no input-to-output bypass; minimum enqueue-to-fpu_valid_o latency is 1 cycle.
REQ-021 SHALL drive in_ready_o = (usage_o != Depth) & !flush_i; a push occurs on in_valid_i & in_ready_o.
REQ-022 SHALL drive fpu_valid_o = (usage_o != 0) & state==RUN & (outstanding_o != MaxOutstanding) & !flush_i; fpu_req_o = head entry; a pop/issue occurs on fpu_valid_o & fpu_ready_i.
REQ-023 SHALL hold fpu_req_o stable while fpu_valid_o is high and not yet accepted.
REQ-024 SHALL leave usage_o unchanged on simultaneous push and pop, including when full (pop frees nothing for the same-cycle push; in_ready_o already low when full).
REQ-025 SHALL use wrap-around read/write pointers modulo Depth.
REQ-026 SHALL increment outstanding on issue and decrement on res_valid_i & res_ready_i; both in one cycle leave it unchanged.
REQ-027 SHALL saturate outstanding at 0 on a retire with count 0 (assertion fires; not a functional error path).
REQ-028 SHALL implement states RUN and FENCE; RUN -> FENCE on fence_i; FENCE -> RUN when registered outstanding_o == 0, pulsing fence_done_o for exactly that one cycle.
REQ-029 SHALL, in FENCE, block issue but continue accepting pushes into the queue.
REQ-030 SHALL ignore fence_i while in FENCE; fence_i in RUN with outstanding_o == 0 enters FENCE and completes on the next cycle.
REQ-031 SHALL, on flush_i, clear FIFO pointers and usage, zero outstanding, force state RUN, suppress fence_done_o, and ignore same-cycle push, issue, retire and fence_i.

Reset
REQ-032 SHALL, during rst_ni low, hold: usage_o=0, outstanding_o=0, state RUN, in_ready_o=1, fpu_valid_o=0, fence_done_o=0, busy_o=0; fpu_req_o value is don't-care.
REQ-033 SHALL abandon any queued or in-flight bookkeeping on reset asserted mid-operation, with no fence_done_o pulse.

Verification
REQ-034 SHALL cover: push A,B,C,D with fpu_ready_i=0 -> usage_o=4, in_ready_o=0; then fpu_ready_i=1 -> issue order A,B,C,D on consecutive cycles.
REQ-035 SHALL cover: MaxOutstanding=8, 9 queued requests, no retires -> exactly 8 issues, fpu_valid_o=0, outstanding_o=8; one retire -> 9th issues the next cycle.
REQ-036 SHALL cover: outstanding_o=3, fence_i -> no issue; after 3 retires outstanding_o=0 and fence_done_o pulses one cycle; issue resumes the next cycle.
REQ-037 SHALL cover: full queue, outstanding_o=5, flush_i together with in_valid_i and a retire -> next cycle usage_o=0, outstanding_o=0, busy_o=0; the pushed request is dropped.
REQ-038 SHALL cover: usage_o=2 with push and pop in the same cycle, repeated 10 cycles across pointer wrap -> usage_o stays 2 and FIFO order is preserved.
REQ-039 SHALL cover: rst_ni asserted in FENCE with usage_o=3 -> all outputs take REQ-032 values asynchronously, and no fence_done_o pulse occurs.
